// File: rtl/nec_ir_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : nec_ir_receiver                                            |
// | Description : NEC IR frame receiver. Synchronises and deglitches the     |
// |               envelope, times marks/spaces and checks inverse bytes.     |
// |               Optional repeat-code support: define NEC_REPEAT_EN.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module nec_ir_receiver #(
  parameter int CLK_FREQ      = 125_000_000,
  parameter int TOL_PCT       = 25,
  parameter int GLITCH_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ir_in,
  output logic [7:0] addr,
  output logic [7:0] cmd,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic       rpt
);

  function automatic logic [63:0] f_win(input logic [63:0] us, input int pct);
    logic [63:0] nom;
    nom = us * 64'(CLK_FREQ) / 64'd1_000_000;
    return nom * 64'(pct) / 64'd100;
  endfunction

  localparam int c_lo = 100 - TOL_PCT;
  localparam int c_hi = 100 + TOL_PCT;
  localparam logic [63:0] c_lm_max_w = f_win(64'd9000, c_hi);
  localparam int c_cw = $clog2(c_lm_max_w + 64'd2);
  localparam int c_gw = $clog2(GLITCH_CYCLES) + 1;

  typedef logic [c_cw-1:0] cnt_t;
  typedef logic [c_gw-1:0] gcnt_t;

  localparam cnt_t c_lm_min = cnt_t'(f_win(64'd9000, c_lo));
  localparam cnt_t c_lm_max = cnt_t'(c_lm_max_w);
  localparam cnt_t c_ls_min = cnt_t'(f_win(64'd4500, c_lo));
  localparam cnt_t c_ls_max = cnt_t'(f_win(64'd4500, c_hi));
  localparam cnt_t c_bm_min = cnt_t'(f_win(64'd562, c_lo));
  localparam cnt_t c_bm_max = cnt_t'(f_win(64'd562, c_hi));
  localparam cnt_t c_b0_min = cnt_t'(f_win(64'd562, c_lo));
  localparam cnt_t c_b0_max = cnt_t'(f_win(64'd562, c_hi));
  localparam cnt_t c_b1_min = cnt_t'(f_win(64'd1687, c_lo));
  localparam cnt_t c_b1_max = cnt_t'(f_win(64'd1687, c_hi));
  localparam cnt_t c_sm_min = cnt_t'(f_win(64'd562, c_lo));
  localparam cnt_t c_sm_max = cnt_t'(f_win(64'd562, c_hi));
`ifdef NEC_REPEAT_EN
  localparam cnt_t c_rs_min = cnt_t'(f_win(64'd2250, c_lo));
  localparam cnt_t c_rs_max = cnt_t'(f_win(64'd2250, c_hi));
`endif

  function automatic logic f_in(input cnt_t d, input cnt_t lo, input cnt_t hi);
    return (d >= lo) && (d <= hi);
  endfunction

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_MARK  = 3'd1,
    S_LEAD_SPACE = 3'd2,
    S_BIT_MARK   = 3'd3,
    S_BIT_SPACE  = 3'd4,
`ifdef NEC_REPEAT_EN
    S_RPT_STOP   = 3'd6,
`endif
    S_STOP_MARK  = 3'd5
  } state_t;

  logic [1:0]  r_sync;
  logic        r_filt;
  logic        r_filt_d;
  gcnt_t       r_gcnt;
  cnt_t        r_cnt;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_shift;
  logic [31:0] w_shift_nxt;
  logic [5:0]  r_bit_cnt;
  logic [5:0]  w_bit_cnt_nxt;
  logic        r_valid;
  logic        r_err;
  logic [7:0]  r_addr;
  logic [7:0]  r_cmd;
  logic        w_valid_nxt;
  logic        w_err_nxt;
  logic        w_rise;
  logic        w_fall;
  logic        w_edge;
  logic        w_bit1;
  logic        w_inv_ok;

  // Filter comes out of reset high, so a line already high is not seen as a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= 2'b11;
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_gcnt   <= '0;
    end else begin
      r_sync   <= {r_sync[0], ir_in};
      r_filt_d <= r_filt;
      if (r_sync[1] == r_filt) begin
        r_gcnt <= '0;
      end else if (r_gcnt == gcnt_t'(GLITCH_CYCLES - 1)) begin
        r_filt <= r_sync[1];
        r_gcnt <= '0;
      end else begin
        r_gcnt <= r_gcnt + 1'b1;
      end
    end
  end

  assign w_rise   = r_filt & ~r_filt_d;
  assign w_fall   = ~r_filt & r_filt_d;
  assign w_edge   = r_filt ^ r_filt_d;
  assign w_bit1   = f_in(r_cnt, c_b1_min, c_b1_max);
  assign w_inv_ok = (r_shift[23:16] == ~r_shift[31:24]) && (r_shift[7:0] == ~r_shift[15:8]);

`ifdef NEC_REPEAT_EN
  logic r_rpt;
  logic r_seen_good;
  logic w_rpt_nxt;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_valid_nxt   = 1'b0;
    w_err_nxt     = 1'b0;
`ifdef NEC_REPEAT_EN
    w_rpt_nxt     = 1'b0;
`endif
    case (r_state)
      S_IDLE: if (w_rise) w_state_nxt = S_LEAD_MARK;
      S_LEAD_MARK: begin
        if (w_fall) begin
          if (f_in(r_cnt, c_lm_min, c_lm_max)) w_state_nxt = S_LEAD_SPACE;
          else                                  w_err_nxt   = 1'b1;
        end else if (r_cnt > c_lm_max) w_err_nxt = 1'b1;
      end
      S_LEAD_SPACE: begin
        if (w_rise) begin
          if (f_in(r_cnt, c_ls_min, c_ls_max)) begin
            w_state_nxt   = S_BIT_MARK;
            w_bit_cnt_nxt = '0;
          end
`ifdef NEC_REPEAT_EN
          else if (f_in(r_cnt, c_rs_min, c_rs_max)) w_state_nxt = S_RPT_STOP;
`endif
          else w_err_nxt = 1'b1;
        end else if (r_cnt > c_ls_max) w_err_nxt = 1'b1;
      end
      S_BIT_MARK: begin
        if (w_fall) begin
          if (f_in(r_cnt, c_bm_min, c_bm_max)) w_state_nxt = S_BIT_SPACE;
          else                                  w_err_nxt   = 1'b1;
        end else if (r_cnt > c_bm_max) w_err_nxt = 1'b1;
      end
      S_BIT_SPACE: begin
        if (w_rise) begin
          if (w_bit1 || f_in(r_cnt, c_b0_min, c_b0_max)) begin
            w_shift_nxt   = {r_shift[30:0], w_bit1};
            w_bit_cnt_nxt = r_bit_cnt + 6'd1;
            w_state_nxt   = (r_bit_cnt == 6'd31) ? S_STOP_MARK : S_BIT_MARK;
          end else w_err_nxt = 1'b1;
        end else if (r_cnt > c_b1_max) w_err_nxt = 1'b1;
      end
      S_STOP_MARK: begin
        if (w_fall) begin
          if (f_in(r_cnt, c_sm_min, c_sm_max) && w_inv_ok) begin
            w_valid_nxt = 1'b1;
            w_state_nxt = S_IDLE;
          end else w_err_nxt = 1'b1;
        end else if (r_cnt > c_sm_max) w_err_nxt = 1'b1;
      end
`ifdef NEC_REPEAT_EN
      S_RPT_STOP: begin
        if (w_fall) begin
          if (f_in(r_cnt, c_sm_min, c_sm_max) && r_seen_good) begin
            w_rpt_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end else w_err_nxt = 1'b1;
        end else if (r_cnt > c_sm_max) w_err_nxt = 1'b1;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_err_nxt) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_cmd     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_valid   <= w_valid_nxt;
      r_err     <= w_err_nxt;
      if (w_edge)            r_cnt <= '0;
      else if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      if (w_valid_nxt) begin
        r_addr <= r_shift[31:24];
        r_cmd  <= r_shift[15:8];
      end
    end
  end

`ifdef NEC_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rpt       <= 1'b0;
      r_seen_good <= 1'b0;
    end else begin
      r_rpt <= w_rpt_nxt;
      if (w_valid_nxt) r_seen_good <= 1'b1;
    end
  end
  assign rpt = r_rpt;
`else
  assign rpt = 1'b0;
`endif

  assign addr      = r_addr;
  assign cmd       = r_cmd;
  assign valid     = r_valid;
  assign frame_err = r_err;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
